// File: rtl/uart_pkg.sv
// Shared types and helpers for the multi-byte UART frame link.
// Line levels, character geometry, FSM encodings and width helpers.
package uart_pkg;

  localparam logic LINE_IDLE     = 1'b1;
  localparam int   BITS_PER_CHAR = 10;
  localparam int   DATA_BITS     = BITS_PER_CHAR - 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int frame_w(input int n);
    return 8 * n;
  endfunction

endpackage

// File: rtl/uart_frame_transceiver_if.sv
// Frame-level handshake between the UART link and its client logic.
// master = command decoder / sensor side, slave = the transceiver.
interface uart_frame_transceiver_if
  import uart_pkg::*;
#(
  parameter int FRAME_BYTES = 2
);
  logic [frame_w(FRAME_BYTES)-1:0] rxFrame;
  logic                            rxValid;
  logic                            rxError;
  logic [frame_w(FRAME_BYTES)-1:0] txFrame;
  logic                            txStart;
  logic                            txBusy;
  logic                            txDone;

  modport master (
    output txFrame, txStart,
    input  rxFrame, rxValid, rxError, txBusy, txDone
  );

  modport slave (
    input  txFrame, txStart,
    output rxFrame, rxValid, rxError, txBusy, txDone
  );
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-time down-counter: full or half-bit load, auto-reload, tick at zero.
// Ticks only while enabled and not being loaded this cycle.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic load_i,
  input  logic half_i,
  output logic tick_o
);
  localparam int CW = clog2(CLKS);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(CLKS - 1);
    end else if (half_i) begin
      cnt_d = CW'(CLKS / 2 - 1);
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? CW'(CLKS - 1) : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = en_i && !load_i && !half_i && (cnt_q == '0);

endmodule

// File: rtl/uart_frame_transceiver.sv
// Full-duplex 8N1 UART moving FRAME_BYTES-byte frames each way.
// Detects framing errors, false starts and inter-byte timeouts.
module uart_frame_transceiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FRAME_BYTES  = 2,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx,
  output logic                     tx,
  uart_frame_transceiver_if.slave  bus
);
  localparam int FW  = frame_w(FRAME_BYTES);
  localparam int IW  = clog2(FRAME_BYTES + 1);
  localparam int LIM = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW  = clog2(LIM);

  logic            s1_q, s2_q, rx_s;
  rx_state_e       rx_st_q, rx_st_d;
  logic [2:0]      rbit_q, rbit_d;
  logic [7:0]      sh_q, sh_d;
  logic [FW-1:0]   acc_q, acc_d;
  logic [FW-1:0]   rxf_q, rxf_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   to_q, to_d;
  logic            rval_q, rval_d;
  logic            rerr_q, rerr_d;
  logic            rx_half, rx_en, rx_tick;

  tx_state_e       tx_st_q, tx_st_d;
  logic [2:0]      tbit_q, tbit_d;
  logic [IW-1:0]   tbyte_q, tbyte_d;
  logic [FW-1:0]   tfr_q, tfr_d;
  logic            tx_q, tx_d;
  logic [7:0]      tcur;
  logic            tx_load, tx_en, tx_tick;

  assign rx_s  = s2_q;
  assign rx_en = rx_st_q inside {RX_START, RX_DATA, RX_STOP};
  assign tx_en = tx_st_q inside {TX_START, TX_DATA, TX_STOP};

  uart_baud_counter #(.CLKS(CLKS_PER_BIT)) u_rx_baud (
    .clk_i  (clock),
    .rst_ni (reset),
    .en_i   (rx_en),
    .load_i (1'b0),
    .half_i (rx_half),
    .tick_o (rx_tick)
  );

  uart_baud_counter #(.CLKS(CLKS_PER_BIT)) u_tx_baud (
    .clk_i  (clock),
    .rst_ni (reset),
    .en_i   (tx_en),
    .load_i (tx_load),
    .half_i (1'b0),
    .tick_o (tx_tick)
  );

  always_comb begin
    rx_st_d = rx_st_q;
    rbit_d  = rbit_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    rxf_d   = rxf_q;
    idx_d   = idx_q;
    to_d    = '0;
    rval_d  = 1'b0;
    rerr_d  = 1'b0;
    rx_half = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_st_d = RX_START;
          rx_half = 1'b1;
        end else if (idx_q != '0) begin
          // partial frame pending: abort if the next byte never starts
          if (to_q == TW'(LIM - 1)) begin
            rerr_d = 1'b1;
            idx_d  = '0;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      RX_START: if (rx_tick) begin
        rx_st_d = rx_s ? RX_IDLE : RX_DATA;
        rbit_d  = '0;
      end
      RX_DATA: if (rx_tick) begin
        sh_d   = {rx_s, sh_q[7:1]};
        rbit_d = rbit_q + 3'd1;
        if (rbit_q == 3'(DATA_BITS - 1)) rx_st_d = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        if (rx_s) begin
          acc_d   = (acc_q << 8) | FW'(sh_q);
          rx_st_d = RX_IDLE;
          if (idx_q == IW'(FRAME_BYTES - 1)) begin
            rxf_d  = acc_d;
            rval_d = 1'b1;
            idx_d  = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          rerr_d  = 1'b1;
          idx_d   = '0;
          rx_st_d = RX_BREAK;
        end
      end
      RX_BREAK: if (rx_s) rx_st_d = RX_IDLE;
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_q    <= LINE_IDLE;
      s2_q    <= LINE_IDLE;
      rx_st_q <= RX_IDLE;
      rbit_q  <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      rxf_q   <= '0;
      idx_q   <= '0;
      to_q    <= '0;
      rval_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      s1_q    <= rx;
      s2_q    <= s1_q;
      rx_st_q <= rx_st_d;
      rbit_q  <= rbit_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      rxf_q   <= rxf_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      rval_q  <= rval_d;
      rerr_q  <= rerr_d;
    end
  end

  always_comb begin
    tx_st_d = tx_st_q;
    tbit_d  = tbit_q;
    tbyte_d = tbyte_q;
    tfr_d   = tfr_q;
    tx_load = 1'b0;
    tx_d    = LINE_IDLE;
    unique case (tx_st_q)
      TX_IDLE, TX_DONE: begin
        tx_st_d = TX_IDLE;
        if (bus.txStart) begin
          tx_st_d = TX_START;
          tx_load = 1'b1;
          tfr_d   = bus.txFrame;
          tbyte_d = '0;
        end
      end
      TX_START: if (tx_tick) begin
        tx_st_d = TX_DATA;
        tbit_d  = '0;
      end
      TX_DATA: if (tx_tick) begin
        tbit_d = tbit_q + 3'd1;
        if (tbit_q == 3'(DATA_BITS - 1)) tx_st_d = TX_STOP;
      end
      TX_STOP: if (tx_tick) begin
        if (tbyte_q == IW'(FRAME_BYTES - 1)) begin
          tx_st_d = TX_DONE;
        end else begin
          tx_st_d = TX_START;
          tbyte_d = tbyte_q + 1'b1;
          tfr_d   = tfr_q << 8;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
    // line level registered from next state so tx never glitches
    tcur = tfr_d[FW-1 -: 8];
    if (tx_st_d == TX_START)     tx_d = 1'b0;
    else if (tx_st_d == TX_DATA) tx_d = tcur[tbit_d];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_st_q <= TX_IDLE;
      tbit_q  <= '0;
      tbyte_q <= '0;
      tfr_q   <= '0;
      tx_q    <= LINE_IDLE;
    end else begin
      tx_st_q <= tx_st_d;
      tbit_q  <= tbit_d;
      tbyte_q <= tbyte_d;
      tfr_q   <= tfr_d;
      tx_q    <= tx_d;
    end
  end

  assign tx          = tx_q;
  assign bus.rxFrame = rxf_q;
  assign bus.rxValid = rval_q;
  assign bus.rxError = rerr_q;
  assign bus.txBusy  = tx_en;
  assign bus.txDone  = (tx_st_q == TX_DONE);

endmodule

// File: tb/tb_uart_frame_transceiver.sv
// Directed bench for uart_frame_transceiver at 4 clocks per bit.
// Table-driven RX frames plus hand-written TX, error and loopback cases.
module tb_uart_frame_transceiver;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_drv = 1'b1;
  logic loop_en = 1'b0;
  logic rx_line;
  logic tx;

  int total = 0;
  int bad = 0;
  int nval = 0;
  int nerr = 0;
  int ndone = 0;
  logic [15:0] got[$];

  always #5 clk = ~clk;

  uart_frame_transceiver_if #(.FRAME_BYTES(2)) bus ();

  assign rx_line = loop_en ? tx : rx_drv;

  uart_frame_transceiver #(
    .CLKS_PER_BIT (C),
    .FRAME_BYTES  (2),
    .TIMEOUT_BITS (20)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .rx    (rx_line),
    .tx    (tx),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.rxValid === 1'b1) begin
      nval++;
      got.push_back(bus.rxFrame);
    end
    if (bus.rxError === 1'b1) nerr++;
    if (bus.txDone === 1'b1) ndone++;
  end

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          gap;
    logic [15:0] f;
  } rxv_t;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    cyc(C);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      cyc(C);
    end
    rx_drv = stop;
    cyc(C);
    rx_drv = 1'b1;
  endtask

  function automatic logic txbit(input logic [15:0] f, input int k);
    logic [7:0] b;
    int p;
    b = (k < 40) ? f[15:8] : f[7:0];
    p = (k % 40) / 4;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  initial begin
    rxv_t        vt[4];
    logic [15:0] lf[3];
    int v0, e0, d0, n;
    int tb_bad, bb_bad, dn_bad, pl_bad;

    vt[0] = '{8'hA5, 8'h3C, 0,  16'hA53C};
    vt[1] = '{8'hFF, 8'h00, 7,  16'hFF00};
    vt[2] = '{8'h80, 8'h01, 30, 16'h8001};
    vt[3] = '{8'h5A, 8'hC3, 50, 16'h5AC3};
    lf[0] = 16'hFFFF;
    lf[1] = 16'h0000;
    lf[2] = 16'h8001;

    bus.txFrame = '0;
    bus.txStart = 1'b0;

    // reset and idle
    cyc(3);
    chk("rst_tx", tx, 1);
    rst_n = 1'b1;
    tb_bad = 0; bb_bad = 0; dn_bad = 0; pl_bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (tx !== 1'b1) tb_bad++;
      if (bus.txBusy !== 1'b0) bb_bad++;
      if (bus.txDone !== 1'b0) dn_bad++;
      if (bus.rxValid !== 1'b0 || bus.rxError !== 1'b0) pl_bad++;
      if (bus.rxFrame !== 16'h0) pl_bad++;
      cyc(1);
    end
    chk("idle_tx", tb_bad, 0);
    chk("idle_busy", bb_bad, 0);
    chk("idle_done", dn_bad, 0);
    chk("idle_rx", pl_bad, 0);

    // table-driven RX frames
    for (int i = 0; i < 4; i++) begin
      v0 = nval; e0 = nerr;
      send_byte(vt[i].b0, 1'b1);
      cyc(vt[i].gap);
      send_byte(vt[i].b1, 1'b1);
      cyc(8);
      chk("rx_valid_cnt", nval - v0, 1);
      chk("rx_err_cnt", nerr - e0, 0);
      chk("rx_frame", bus.rxFrame, vt[i].f);
    end

    // TX frame, with an ignored request mid-frame
    d0 = ndone;
    bus.txFrame = 16'h1234;
    bus.txStart = 1'b1;
    cyc(1);
    bus.txStart = 1'b0;
    tb_bad = 0; bb_bad = 0; dn_bad = 0;
    for (int k = 0; k < 80; k++) begin
      if (tx !== txbit(16'h1234, k)) tb_bad++;
      if (bus.txBusy !== 1'b1) bb_bad++;
      if (bus.txDone !== 1'b0) dn_bad++;
      if (k == 40) begin
        bus.txFrame = 16'hAAAA;
        bus.txStart = 1'b1;
      end
      if (k == 41) bus.txStart = 1'b0;
      cyc(1);
    end
    chk("tx_bits", tb_bad, 0);
    chk("tx_busy_hi", bb_bad, 0);
    chk("tx_done_early", dn_bad, 0);
    chk("tx_done_pulse", bus.txDone, 1);
    chk("tx_busy_fall", bus.txBusy, 0);
    chk("tx_stop_idle", tx, 1);
    cyc(1);
    chk("tx_done_once", bus.txDone, 0);
    cyc(5);
    chk("tx_done_cnt", ndone - d0, 1);

    // framing error then recovery
    v0 = nval; e0 = nerr;
    send_byte(8'h55, 1'b0);
    cyc(10);
    chk("fe_err", nerr - e0, 1);
    chk("fe_noval", nval - v0, 0);
    chk("fe_hold", bus.rxFrame, vt[3].f);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    cyc(8);
    chk("fe_rec_val", nval - v0, 1);
    chk("fe_rec_frame", bus.rxFrame, 16'h0102);

    // inter-byte timeout
    v0 = nval; e0 = nerr;
    send_byte(8'h11, 1'b1);
    cyc(60);
    chk("to_early", nerr - e0, 0);
    cyc(40);
    chk("to_err", nerr - e0, 1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    cyc(8);
    chk("to_val", nval - v0, 1);
    chk("to_frame", bus.rxFrame, 16'h2233);
    chk("to_err_after", nerr - e0, 1);

    // glitch while idle
    v0 = nval; e0 = nerr;
    rx_drv = 1'b0;
    cyc(1);
    rx_drv = 1'b1;
    cyc(20);
    chk("gl_err", nerr - e0, 0);
    chk("gl_val", nval - v0, 0);

    // loopback, back-to-back frames
    loop_en = 1'b1;
    got.delete();
    v0 = nval; e0 = nerr;
    bus.txFrame = lf[0];
    bus.txStart = 1'b1;
    cyc(1);
    bus.txStart = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      n = 0;
      while (bus.txDone !== 1'b1 && n < 200) begin
        cyc(1);
        n++;
      end
      chk("lb_done_wait", n < 200, 1);
      if (i < 3) begin
        bus.txFrame = lf[i];
        bus.txStart = 1'b1;
        cyc(1);
        bus.txStart = 1'b0;
        chk("lb_accept", bus.txBusy, 1);
      end
    end
    cyc(20);
    chk("lb_val_cnt", nval - v0, 3);
    chk("lb_err_cnt", nerr - e0, 0);
    for (int i = 0; i < 3; i++)
      chk("lb_frame", (got.size() > i) ? got[i] : 16'hxxxx, lf[i]);
    loop_en = 1'b0;

    // reset during a transmission
    bus.txFrame = 16'h00FF;
    bus.txStart = 1'b1;
    cyc(1);
    bus.txStart = 1'b0;
    cyc(2);
    chk("mr_pre_tx", tx, 0);
    rst_n = 1'b0;
    cyc(1);
    chk("mr_tx", tx, 1);
    chk("mr_busy", bus.txBusy, 0);
    chk("mr_rxframe", bus.rxFrame, 0);
    rst_n = 1'b1;
    cyc(5);
    chk("mr_after_tx", tx, 1);
    chk("mr_after_busy", bus.txBusy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
